// File: rtl/random_range.sv
// Parametrised LFSR random source with runtime reseeding, a zero-lockup guard
// and a rejection-sampling range sampler behind a request/response handshake.
module random_range #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(8'h01),
   parameter int unsigned      OUT_W     = 5,
   parameter int unsigned      MAX_TRIES = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             update_i,
   input  logic             seed_valid_i,
   input  logic [WIDTH-1:0] seed_data_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [OUT_W-1:0] req_limit_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [OUT_W-1:0] rsp_value_o,
   output logic             rsp_fallback_o,
   output logic [WIDTH-1:0] raw_o,
   output logic             busy_o
);

   localparam int unsigned LIM_W = OUT_W + 1;
   localparam int unsigned CNT_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);
   localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   lfsr_q, lfsr_d;
   logic [LIM_W-1:0]   limit_q, limit_d;
   logic [CNT_W-1:0]   attempts_q, attempts_d;
   logic [OUT_W-1:0]   rsp_value_q, rsp_value_d;
   logic               rsp_fallback_q, rsp_fallback_d;

   logic [WIDTH-1:0]   lfsr_step;
   logic [LIM_W-1:0]   candidate;

   assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
   assign candidate = {1'b0, lfsr_q[OUT_W-1:0]};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // LFSR and sampler datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q         <= SEED;
         limit_q        <= '0;
         attempts_q     <= '0;
         rsp_value_q    <= '0;
         rsp_fallback_q <= 1'b0;
      end else begin
         lfsr_q         <= lfsr_d;
         limit_q        <= limit_d;
         attempts_q     <= attempts_d;
         rsp_value_q    <= rsp_value_d;
         rsp_fallback_q <= rsp_fallback_d;
      end
   end

   // LFSR next value: seed load beats a forced draw step beats a free-running step
   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_valid_i) begin
         lfsr_d = (seed_data_i == '0) ? SEED : seed_data_i;
      end else if ((state_q == DRAW) || update_i) begin
         lfsr_d = (lfsr_step == '0) ? SEED : lfsr_step;
      end
   end

   // Sampler next state; a seed load during DRAW stalls evaluation for that cycle
   always_comb begin
      state_d        = state_q;
      limit_d        = limit_q;
      attempts_d     = attempts_q;
      rsp_value_d    = rsp_value_q;
      rsp_fallback_d = rsp_fallback_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               limit_d    = (req_limit_i == '0) ? {1'b1, {OUT_W{1'b0}}}
                                                : {1'b0, req_limit_i};
               attempts_d = '0;
               state_d    = DRAW;
            end
         end
         DRAW: begin
            if (!seed_valid_i) begin
               if (candidate < limit_q) begin
                  rsp_value_d    = lfsr_q[OUT_W-1:0];
                  rsp_fallback_d = 1'b0;
                  state_d        = HOLD;
               end else if (attempts_q == LAST_TRY) begin
                  rsp_value_d    = '0;
                  rsp_fallback_d = 1'b1;
                  state_d        = HOLD;
               end else begin
                  attempts_d = attempts_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and status outputs decoded from the registered state
   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      busy_o      = 1'b1;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         HOLD: begin
            rsp_valid_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign rsp_value_o    = rsp_value_q;
   assign rsp_fallback_o = rsp_fallback_q;
   assign raw_o          = lfsr_q;

endmodule

// File: tb/tb_random_range.sv
// Bench for random_range: hand-computed vector table, corner sequences, and
// randomized requests checked against an arithmetic LFSR/sampler model.
module tb_random_range;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Two 8-bit instances: [0] defaults, [1] MAX_TRIES=4
   logic       upd [2];
   logic       sv  [2];
   logic [7:0] sd  [2];
   logic       rqv [2];
   logic [4:0] lim [2];
   logic       rsr [2];
   logic       rqr [2];
   logic       rspv[2];
   logic [4:0] val [2];
   logic       fbk [2];
   logic [7:0] raw [2];
   logic       bsy [2];

   random_range u_dflt (
      .clk(clk), .rst_n(rst_n), .update_i(upd[0]), .seed_valid_i(sv[0]),
      .seed_data_i(sd[0]), .req_valid_i(rqv[0]), .req_ready_o(rqr[0]),
      .req_limit_i(lim[0]), .rsp_valid_o(rspv[0]), .rsp_ready_i(rsr[0]),
      .rsp_value_o(val[0]), .rsp_fallback_o(fbk[0]), .raw_o(raw[0]), .busy_o(bsy[0]));

   random_range #(.MAX_TRIES(4)) u_mt4 (
      .clk(clk), .rst_n(rst_n), .update_i(upd[1]), .seed_valid_i(sv[1]),
      .seed_data_i(sd[1]), .req_valid_i(rqv[1]), .req_ready_o(rqr[1]),
      .req_limit_i(lim[1]), .rsp_valid_o(rspv[1]), .rsp_ready_i(rsr[1]),
      .rsp_value_o(val[1]), .rsp_fallback_o(fbk[1]), .raw_o(raw[1]), .busy_o(bsy[1]));

   // Legacy 4-bit generator configuration
   logic       w4_upd;
   logic       w4_rqr, w4_rspv, w4_fb, w4_bsy;
   logic [2:0] w4_val;
   logic [3:0] w4_raw;
   random_range #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'b1011), .OUT_W(3)) u_w4 (
      .clk(clk), .rst_n(rst_n), .update_i(w4_upd), .seed_valid_i(1'b0),
      .seed_data_i(4'h0), .req_valid_i(1'b0), .req_ready_o(w4_rqr),
      .req_limit_i(3'd0), .rsp_valid_o(w4_rspv), .rsp_ready_i(1'b0),
      .rsp_value_o(w4_val), .rsp_fallback_o(w4_fb), .raw_o(w4_raw), .busy_o(w4_bsy));

   // Tap mask without the MSB so a nonzero state can step to zero
   logic       lk_upd, lk_sv;
   logic [3:0] lk_sd;
   logic       lk_rqr, lk_rspv, lk_fb, lk_bsy;
   logic [1:0] lk_val;
   logic [3:0] lk_raw;
   random_range #(.WIDTH(4), .TAPS(4'b0001), .SEED(4'b0011), .OUT_W(2), .MAX_TRIES(1)) u_lk (
      .clk(clk), .rst_n(rst_n), .update_i(lk_upd), .seed_valid_i(lk_sv),
      .seed_data_i(lk_sd), .req_valid_i(1'b0), .req_ready_o(lk_rqr),
      .req_limit_i(2'd0), .rsp_valid_o(lk_rspv), .rsp_ready_i(1'b0),
      .rsp_value_o(lk_val), .rsp_fallback_o(lk_fb), .raw_o(lk_raw), .busy_o(lk_bsy));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference LFSR step: shift left, append tap parity, zero replaced by seed
   function automatic int unsigned mstep(input int unsigned x, input int unsigned taps,
                                         input int unsigned w, input int unsigned seed);
      int unsigned ones;
      int unsigned nxt;
      ones = 0;
      for (int i = 0; i < int'(w); i++) if ((((x & taps) >> i) & 1) == 1) ones++;
      nxt = ((x << 1) & ((1 << w) - 1)) | (ones % 2);
      return (nxt == 0) ? seed : nxt;
   endfunction

   // Reference sampler: walk the LFSR sequence until a draw is below the limit
   task automatic model_draw(input int unsigned s, input int unsigned limit,
                             input int unsigned tries, output int n, output int unsigned v,
                             output logic f, output int unsigned after);
      int unsigned bound;
      int unsigned cand;
      bound = (limit == 0) ? 32 : limit;
      n = int'(tries); v = 0; f = 1'b1;
      for (int k = 1; k <= int'(tries); k++) begin
         cand = s % 32;
         s = mstep(s, 32'hB8, 8, 1);
         if (cand < bound) begin
            n = k; v = cand; f = 1'b0;
            break;
         end
      end
      after = s;
   endtask

   task automatic do_seed(input int d, input logic [7:0] s);
      sv[d] = 1'b1; sd[d] = s;
      @(negedge clk);
      sv[d] = 1'b0; sd[d] = 8'h00;
   endtask

   // Issue one request; optionally pulse seed_valid at sample index stall_at
   task automatic do_req(input int d, input logic [4:0] limit, input int stall_at,
                         input logic [7:0] stall_seed, output int lat,
                         output logic [4:0] v, output logic f);
      check("req_ready before request", rqr[d], 1);
      rqv[d] = 1'b1; lim[d] = limit;
      @(negedge clk);
      rqv[d] = 1'b0;
      lat = 1;
      check("req_ready in draw", rqr[d], 0);
      check("busy in draw", bsy[d], 1);
      while (rspv[d] !== 1'b1 && lat < 100) begin
         sv[d] = (lat == stall_at);
         sd[d] = stall_seed;
         @(negedge clk);
         lat++;
      end
      sv[d] = 1'b0; sd[d] = 8'h00;
      v = val[d]; f = fbk[d];
   endtask

   task automatic do_release(input int d);
      rsr[d] = 1'b1;
      @(negedge clk);
      rsr[d] = 1'b0;
      check("rsp_valid after release", rspv[d], 0);
      check("req_ready after release", rqr[d], 1);
      check("busy after release", bsy[d], 0);
   endtask

   typedef struct {
      int         d;
      logic [7:0] seed;
      logic [4:0] limit;
      int         stall_at;
      logic [7:0] stall_seed;
      logic [4:0] exp_val;
      logic       exp_fb;
      int         exp_lat;
      logic [7:0] exp_raw;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, n;
      logic [4:0]  v;
      logic        f;
      int unsigned m, mw, ev, after, s, limit;
      logic        ef;
      logic [3:0]  w4exp [4];
      int          d, k;

      tbl[0] = '{0, 8'h01, 5'd0,  0, 8'h00, 5'd1,  1'b0, 2,  8'h02};
      tbl[1] = '{0, 8'h08, 5'd4,  0, 8'h00, 5'd3,  1'b0, 4,  8'h47};
      tbl[2] = '{0, 8'h01, 5'd1,  0, 8'h00, 5'd0,  1'b1, 16, 8'h25};
      tbl[3] = '{0, 8'h04, 5'd3,  0, 8'h00, 5'd2,  1'b0, 11, 8'hC4};
      tbl[4] = '{0, 8'h00, 5'd0,  0, 8'h00, 5'd1,  1'b0, 2,  8'h02};
      tbl[5] = '{0, 8'hFF, 5'd31, 0, 8'h00, 5'd30, 1'b0, 3,  8'hFC};
      tbl[6] = '{0, 8'h47, 5'd8,  0, 8'h00, 5'd7,  1'b0, 2,  8'h8E};
      tbl[7] = '{0, 8'h04, 5'd3,  2, 8'h02, 5'd2,  1'b0, 4,  8'h04};
      tbl[8] = '{1, 8'h01, 5'd1,  0, 8'h00, 5'd0,  1'b1, 5,  8'h11};
      tbl[9] = '{1, 8'h01, 5'd1,  2, 8'h01, 5'd0,  1'b1, 6,  8'h08};
      w4exp[0] = 4'b0110; w4exp[1] = 4'b1100; w4exp[2] = 4'b1001; w4exp[3] = 4'b0010;

      for (int i = 0; i < 2; i++) begin
         upd[i] = 0; sv[i] = 0; sd[i] = 0; rqv[i] = 0; lim[i] = 0; rsr[i] = 0;
      end
      w4_upd = 0; lk_upd = 0; lk_sv = 0; lk_sd = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      check("reset req_ready", rqr[0], 1);
      check("reset rsp_valid", rspv[0], 0);
      check("reset rsp_value", val[0], 0);
      check("reset rsp_fallback", fbk[0], 0);
      check("reset busy", bsy[0], 0);
      check("reset raw", raw[0], 8'h01);
      check("reset raw w4", w4_raw, 4'b1011);
      check("reset raw lockup", lk_raw, 4'b0011);
      rst_n = 1'b1;
      @(negedge clk);

      // Legacy 4-bit sequence, period 15
      mw = 4'b1011;
      w4_upd = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         mw = mstep(mw, 4'b1001, 4, 4'b1011);
         check("w4 raw vs model", w4_raw, mw);
         if (i <= 4) check("w4 raw legacy", w4_raw, w4exp[i-1]);
         if (i < 15) check("w4 early repeat", w4_raw == 4'b1011, 0);
      end
      w4_upd = 1'b0;
      check("w4 period 15", w4_raw, 4'b1011);

      // Zero-lockup guard and zero seed
      lk_sv = 1'b1; lk_sd = 4'b1000;
      @(negedge clk);
      lk_sv = 1'b0; lk_sd = 4'b0000;
      check("lockup seeded", lk_raw, 4'b1000);
      lk_upd = 1'b1;
      @(negedge clk);
      lk_upd = 1'b0;
      check("lockup guard", lk_raw, 4'b0011);
      lk_sv = 1'b1; lk_sd = 4'b0101;
      @(negedge clk);
      lk_sd = 4'b0000;
      @(negedge clk);
      lk_sv = 1'b0;
      check("lockup zero seed", lk_raw, 4'b0011);

      // Default period 255, never zero
      do_seed(0, 8'h01);
      m = 1;
      upd[0] = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         @(negedge clk);
         m = mstep(m, 32'hB8, 8, 1);
         check("p255 raw vs model", raw[0], m);
         check("p255 nonzero", raw[0] != 8'h00, 1);
         if (i < 255) check("p255 early repeat", raw[0] == 8'h01, 0);
      end
      upd[0] = 1'b0;
      check("p255 period", raw[0], 8'h01);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         d = tbl[i].d;
         do_seed(d, tbl[i].seed);
         check("tbl seeded raw", raw[d], (tbl[i].seed == 8'h00) ? 8'h01 : tbl[i].seed);
         do_req(d, tbl[i].limit, tbl[i].stall_at, tbl[i].stall_seed, lat, v, f);
         check("tbl rsp_value", v, tbl[i].exp_val);
         check("tbl rsp_fallback", f, tbl[i].exp_fb);
         check("tbl latency", lat, tbl[i].exp_lat);
         check("tbl raw after", raw[d], tbl[i].exp_raw);
         do_release(d);
         check("tbl raw after release", raw[d], tbl[i].exp_raw);
      end

      // HOLD stability with random update and a blocked new request
      do_seed(0, 8'h08);
      do_req(0, 5'd4, 0, 8'h00, lat, v, f);
      check("hold value", v, 3);
      m = 8'h47;
      rqv[0] = 1'b1; lim[0] = 5'd0;
      for (int i = 0; i < 10; i++) begin
         upd[0] = 1'($urandom % 2);
         @(negedge clk);
         if (upd[0]) m = mstep(m, 32'hB8, 8, 1);
         check("hold rsp_valid", rspv[0], 1);
         check("hold rsp_value", val[0], 3);
         check("hold req_ready", rqr[0], 0);
         check("hold raw", raw[0], m);
      end
      upd[0] = 1'b0;
      rqv[0] = 1'b0;
      do_seed(0, 8'h00);
      check("hold zero seed raw", raw[0], 8'h01);
      check("hold still valid", rspv[0], 1);
      check("hold value after seed", val[0], 3);
      do_release(0);

      // Randomized requests against the model
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom % 2);
         s = ($urandom % 8 == 0) ? 0 : ($urandom % 256);
         limit = $urandom % 32;
         do_seed(d, 8'(s));
         m = (s == 0) ? 1 : s;
         model_draw(m, limit, (d == 1) ? 4 : 15, n, ev, ef, after);
         do_req(d, 5'(limit), 0, 8'h00, lat, v, f);
         check("rand rsp_value", v, ev);
         check("rand rsp_fallback", f, ef);
         check("rand latency", lat, n + 1);
         check("rand raw after", raw[d], after);
         m = after;
         k = int'($urandom % 4);
         for (int j = 0; j < k; j++) begin
            upd[d] = 1'($urandom % 2);
            @(negedge clk);
            if (upd[d]) m = mstep(m, 32'hB8, 8, 1);
            check("rand hold raw", raw[d], m);
            check("rand hold value", val[d], ev);
         end
         upd[d] = 1'b0;
         do_release(d);
         check("rand raw after release", raw[d], m);
      end

      // Asynchronous reset in the middle of a draw
      do_seed(0, 8'h01);
      rqv[0] = 1'b1; lim[0] = 5'd1;
      @(negedge clk);
      rqv[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset busy", bsy[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset req_ready", rqr[0], 1);
      check("async reset rsp_valid", rspv[0], 0);
      check("async reset busy", bsy[0], 0);
      check("async reset rsp_value", val[0], 0);
      check("async reset rsp_fallback", fbk[0], 0);
      check("async reset raw", raw[0], 8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      do_req(0, 5'd0, 0, 8'h00, lat, v, f);
      check("post-reset rsp_value", v, 1);
      check("post-reset rsp_fallback", f, 0);
      check("post-reset latency", lat, 2);
      check("post-reset raw", raw[0], 8'h02);
      do_release(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/random_range.md
Name: random_range

Overview:
- Parametrised LFSR random source. Generalises the fixed 4/5-bit generators to any width and tap mask.
- Adds runtime reseeding, zero-lockup protection, and a bounded-range sampler with a request/response handshake.
- The sampler uses rejection sampling with a fallback.
- Game logic (food placement, etc.) requests a value in [0, limit) and receives it several cycles later. The raw LFSR state stays available for free-running uses.

Parameters:
WIDTH, 8, LFSR width (3..16)
TAPS, 8'hB8, feedback mask; bit i set = lfsr[i] included in feedback parity
SEED, 8'h01, reset/recovery value; must be nonzero
OUT_W, 5, sampler output width (OUT_W <= WIDTH)
MAX_TRIES, 15, rejected draws before fallback (>= 1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
update  input  1  step LFSR once (free-running mode)
seed_valid  input  1  load seed_data into LFSR
seed_data  input  WIDTH  new seed; 0 means use SEED
req_valid  input  1  sample request
req_ready  output  1  request accepted when req_valid && req_ready
req_limit  input  OUT_W  exclusive upper bound; 0 means 2^OUT_W
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_value  output  OUT_W  sampled value, < limit
rsp_fallback  output  1  value is fallback 0 after MAX_TRIES rejections
raw  output  WIDTH  current LFSR register
busy  output  1  sampler not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low, and acts on all state immediately, including mid-draw. No response is produced for an in-flight request.
- Reset values: lfsr=SEED, state=IDLE, req_ready=1, rsp_valid=0, rsp_value=0, rsp_fallback=0, busy=0.
- LFSR step: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. WIDTH=4, TAPS=4'b1001 reproduces the legacy 4-bit generator.
- Lockup guard: if the next lfsr value would be 0, SEED is loaded instead.
- LFSR priority per cycle:
  1. seed_valid loads the seed (seed_data, or SEED if seed_data==0).
  2. Otherwise, state==DRAW forces exactly one step.
  3. Otherwise, update steps once.
  - update is ignored during DRAW; there is never a double step.
- Sampler FSM:
  - IDLE: req_ready=1.
    - On req_valid: latch limit_eff = (req_limit==0) ? 2^OUT_W : req_limit (OUT_W+1 bits), clear attempt counter, go DRAW.
  - DRAW: req_ready=0.
    - candidate = lfsr[OUT_W-1:0], taken before this cycle's step.
    - If candidate < limit_eff: rsp_value<=candidate, rsp_fallback<=0, go HOLD.
    - Else attempts++. If attempts reaches MAX_TRIES: rsp_value<=0, rsp_fallback<=1, go HOLD.
    - Else stay in DRAW.
    - If seed_valid is high in a DRAW cycle: seed loads, no candidate is evaluated, no attempt is counted (draw stalls one cycle).
  - HOLD: rsp_valid=1, rsp_value/rsp_fallback stable while rsp_ready=0.
    - On rsp_ready: go IDLE, rsp_valid drops the next cycle.
    - No new request is accepted in the same cycle (req_ready=0 in HOLD).
- Latency: acceptance at edge T with success on attempt N → rsp_valid high after edge T+N+1. Fallback → rsp_valid after edge T+MAX_TRIES+1.
- busy = (state != IDLE). req_ready, rsp_valid and busy are decoded from registered state.
- Requests while not IDLE are not accepted. req_valid must be held by the requester.

Test Plan:
- WIDTH=4, TAPS=4'b1001, SEED=4'b1011, update=1 each cycle → raw: 1011, 0110, 1100, 1001, 0010; period 15. Defaults: period 255, never 0.
- Defaults, seed_valid with seed_data=0x01, then req_limit=0 → accepted on attempt 1: rsp_value=1, rsp_fallback=0, rsp_valid 2 cycles after acceptance.
- seed 0x08, req_limit=4, update=0 → candidates 8, 17 rejected, 3 accepted: rsp_value=3, rsp_valid 4 cycles after acceptance, raw=0x47 afterwards.
- MAX_TRIES=4, seed 0x01, req_limit=1 → candidates 1, 2, 4, 8 rejected: rsp_value=0, rsp_fallback=1, rsp_valid 5 cycles after acceptance.
- rsp_ready=0 for 10 cycles in HOLD → rsp_valid, rsp_value stable, req_ready=0, raw changes only on update. seed_valid with 0 → raw=SEED.
- rst_n low asynchronously mid-DRAW → outputs at reset values before the next clk edge, raw=SEED. Following request behaves as from fresh reset.
